toysram_16x12_port_ctl: RTL

- Sequencing controller that drives one 16x12 2R1W 10T toysram subarray from the logic side.
- The subarray holds array cells only. This block decodes addresses into one-hot read and write wordline pulses and drives the write bitline pair.
- It evaluates and registers both read bitline ports, and presents two read request ports and one write request port to the surrounding logic.

---
 rtl/toysram_16x12_port_ctl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/toysram_16x12_port_ctl.sv
// Sequencing controller for a 16x12 2R1W toysram subarray: wordline decode, write bitline drive, read capture.
// Optional write-through forwarding on read/write row collision is enabled by defining TOYSRAM_CTL_RDWR_FWD_EN.
module toysram_16x12_port_ctl #(
  parameter int ROWS           = 16,
  parameter int COLS           = 12,
  parameter int AW             = 4,
  parameter int WL_CYC         = 1,
  parameter int RBL_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd0_req,
  input  logic [AW-1:0]   rd0_addr,
  output logic            rd0_ack,
  output logic            rd0_valid,
  output logic [COLS-1:0] rd0_data,
  input  logic            rd1_req,
  input  logic [AW-1:0]   rd1_addr,
  output logic            rd1_ack,
  output logic            rd1_valid,
  output logic [COLS-1:0] rd1_data,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  output logic            wr_ack,
  output logic [ROWS-1:0] rwl0,
  output logic [ROWS-1:0] rwl1,
  output logic [ROWS-1:0] wwl,
  input  logic [COLS-1:0] rbl0,
  input  logic [COLS-1:0] rbl1,
  output logic [COLS-1:0] wbl,
  output logic [COLS-1:0] wblb,
  output logic            busy
);

  if (WL_CYC < 1 || WL_CYC > 4) begin : g_bad_wl_cyc
    $error("toysram_16x12_port_ctl: WL_CYC must be in 1..4");
  end
  if (ROWS != (1 << AW)) begin : g_bad_aw
    $error("toysram_16x12_port_ctl: ROWS must equal 2**AW");
  end

  typedef enum logic [1:0] {IDLE, PULSE, CAPT} state_t;

  localparam logic [ROWS-1:0] ONE_ROW = ROWS'(1);
  localparam logic [1:0]      LAST    = 2'(WL_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd0_en_q, rd0_en_d, rd1_en_q, rd1_en_d;
  logic            fwd0_q, fwd0_d, fwd1_q, fwd1_d;
  logic [ROWS-1:0] rwl0_q, rwl0_d, rwl1_q, rwl1_d, wwl_q, wwl_d;
  logic [COLS-1:0] wbl_q, wbl_d, wblb_q, wblb_d;
  logic            rd0_valid_q, rd0_valid_d, rd1_valid_q, rd1_valid_d;
  logic [COLS-1:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;

  logic [COLS-1:0] rbl0_val, rbl1_val;
  logic            hit0, hit1, fwd0, fwd1;

  // A precharged bitline discharges for a stored 1 when RBL_ACTIVE_LOW is set.
  assign rbl0_val = (RBL_ACTIVE_LOW != 0) ? ~rbl0 : rbl0;
  assign rbl1_val = (RBL_ACTIVE_LOW != 0) ? ~rbl1 : rbl1;

  assign hit0 = wr_req && rd0_req && (wr_addr == rd0_addr);
  assign hit1 = wr_req && rd1_req && (wr_addr == rd1_addr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd0_en_d    = rd0_en_q;
    rd1_en_d    = rd1_en_q;
    fwd0_d      = fwd0_q;
    fwd1_d      = fwd1_q;
    rwl0_d      = rwl0_q;
    rwl1_d      = rwl1_q;
    wwl_d       = wwl_q;
    wbl_d       = wbl_q;
    wblb_d      = wblb_q;
    rd0_valid_d = 1'b0;
    rd1_valid_d = 1'b0;
    rd0_data_d  = rd0_data_q;
    rd1_data_d  = rd1_data_q;
    rd0_ack     = 1'b0;
    rd1_ack     = 1'b0;
    wr_ack      = 1'b0;
`ifdef TOYSRAM_CTL_RDWR_FWD_EN
    fwd0 = hit0;
    fwd1 = hit1;
`else
    fwd0 = 1'b0;
    fwd1 = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        rd0_ack = rd0_req;
        rd1_ack = rd1_req;
`ifdef TOYSRAM_CTL_RDWR_FWD_EN
        wr_ack = wr_req;
`else
        wr_ack = wr_req && !(hit0 || hit1);
`endif
        if (rd0_ack || rd1_ack || wr_ack) begin
          state_d  = PULSE;
          cnt_d    = 2'd0;
          rd0_en_d = rd0_ack;
          rd1_en_d = rd1_ack;
          fwd0_d   = fwd0;
          fwd1_d   = fwd1;
          // A forwarded read must not open its row while the same row is being written.
          rwl0_d   = (rd0_ack && !fwd0) ? (ONE_ROW << rd0_addr) : '0;
          rwl1_d   = (rd1_ack && !fwd1) ? (ONE_ROW << rd1_addr) : '0;
          wwl_d    = wr_ack ? (ONE_ROW << wr_addr) : '0;
          wbl_d    = wr_ack ? wr_data : '0;
          wblb_d   = wr_ack ? ~wr_data : '0;
        end
      end
      PULSE: begin
        if (cnt_q == LAST) begin
          state_d     = CAPT;
          rwl0_d      = '0;
          rwl1_d      = '0;
          wwl_d       = '0;
          wbl_d       = '0;
          wblb_d      = '0;
          rd0_valid_d = rd0_en_q;
          rd1_valid_d = rd1_en_q;
          if (rd0_en_q) rd0_data_d = fwd0_q ? wbl_q : rbl0_val;
          if (rd1_en_q) rd1_data_d = fwd1_q ? wbl_q : rbl1_val;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CAPT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rwl0_d  = '0;
        rwl1_d  = '0;
        wwl_d   = '0;
        wbl_d   = '0;
        wblb_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      rd0_en_q    <= 1'b0;
      rd1_en_q    <= 1'b0;
      fwd0_q      <= 1'b0;
      fwd1_q      <= 1'b0;
      rwl0_q      <= '0;
      rwl1_q      <= '0;
      wwl_q       <= '0;
      wbl_q       <= '0;
      wblb_q      <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd0_en_q    <= rd0_en_d;
      rd1_en_q    <= rd1_en_d;
      fwd0_q      <= fwd0_d;
      fwd1_q      <= fwd1_d;
      rwl0_q      <= rwl0_d;
      rwl1_q      <= rwl1_d;
      wwl_q       <= wwl_d;
      wbl_q       <= wbl_d;
      wblb_q      <= wblb_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_valid_q <= rd1_valid_d;
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
    end
  end

  assign rwl0      = rwl0_q;
  assign rwl1      = rwl1_q;
  assign wwl       = wwl_q;
  assign wbl       = wbl_q;
  assign wblb      = wblb_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_valid = rd1_valid_q;
  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign busy      = (state_q != IDLE);

endmodule
